branch_predict_unit: RTL

//  Next-generation branch control: keeps the same execute-stage resolve logic and adds a fetch-stage predictor.

---
 rtl/branch_predict_unit_if.sv | 39 +++
 rtl/branch_predict_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute bus of the branch predict unit: fetch pc and prediction, execute-stage
// resolve inputs and the redirect back to the pc mux.
interface branch_predict_unit_if;
    logic [31:0] ifPc;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        exValid;
    logic [31:0] exPc;
    logic [31:0] exPc4;
    logic [31:0] exInstr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        bcuEnable;
    logic        bcuAlways;
    logic        bcuComp;
    logic        bcuReg;
    logic        bcuEq;
    logic [2:0]  bcuCond;
    logic        exLink;
    logic        exReturn;
    logic        exPredTaken;
    logic [31:0] exPredTarget;
    logic        redirect;
    logic [31:0] redirectPc;

    modport master (
        output ifPc, exValid, exPc, exPc4, exInstr, rs, rt,
               bcuEnable, bcuAlways, bcuComp, bcuReg, bcuEq, bcuCond,
               exLink, exReturn, exPredTaken, exPredTarget,
        input  predTaken, predTarget, redirect, redirectPc
    );

    modport slave (
        input  ifPc, exValid, exPc, exPc4, exInstr, rs, rt,
               bcuEnable, bcuAlways, bcuComp, bcuReg, bcuEq, bcuCond,
               exLink, exReturn, exPredTaken, exPredTarget,
        output predTaken, predTarget, redirect, redirectPc
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit: 2-bit BHT + direct-mapped BTB at fetch, branch resolve and redirect at EX.
// Define RAS_EN to add a circular return-address stack that predicts jr $31 targets.
module branch_predict_unit #(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int RAS_DEPTH   = 4
) (
    input logic           clk,
    input logic           rst,
    branch_predict_unit_if.slave bus
);
    localparam int BHT_BITS = $clog2(BHT_ENTRIES);
    localparam int BTB_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = 30 - BTB_BITS;

    logic [1:0]             bht       [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btbValid;
    logic [TAG_BITS-1:0]    btbTag    [BTB_ENTRIES];
    logic [31:0]            btbTarget [BTB_ENTRIES];

    logic                rsZero;
    logic                condComp;
    logic                cond;
    logic                taken;
    logic [31:0]         immExt;
    logic [31:0]         target;
    logic [31:0]         actualNext;
    logic                exUpdate;
    logic [BHT_BITS-1:0] exBhtIdx;
    logic [BTB_BITS-1:0] exBtbIdx;
    logic [TAG_BITS-1:0] exTag;

    logic [BHT_BITS-1:0] ifBhtIdx;
    logic [BTB_BITS-1:0] ifBtbIdx;
    logic [TAG_BITS-1:0] ifTag;
    logic                btbHit;
    logic [31:0]         ifPc4;

    assign rsZero   = (bus.rs == 32'd0);
    assign condComp = (bus.bcuCond[0] & rsZero)
                    | (bus.bcuCond[1] & ~bus.rs[31] & ~rsZero)
                    | (bus.bcuCond[2] & bus.rs[31]);
    assign cond     = bus.bcuComp ? condComp : (bus.bcuEq ^ (bus.rs != bus.rt));
    assign taken    = bus.bcuEnable & (bus.bcuAlways | cond);

    assign immExt     = {{14{bus.exInstr[15]}}, bus.exInstr[15:0], 2'b00};
    assign target     = bus.bcuAlways ? (bus.bcuReg ? bus.rs : {bus.exPc4[31:28], bus.exInstr[25:0], 2'b00})
                                      : bus.exPc4 + immExt;
    assign actualNext = taken ? target : bus.exPc4;

    // The redirect compares against the full predicted next pc, so a correct taken guess with a stale target still flushes.
    assign bus.redirect   = bus.exValid & (actualNext != bus.exPredTarget);
    assign bus.redirectPc = actualNext;

    assign exUpdate = bus.exValid & bus.bcuEnable;
    assign exBhtIdx = bus.exPc[BHT_BITS+1:2];
    assign exBtbIdx = bus.exPc[BTB_BITS+1:2];
    assign exTag    = bus.exPc[31:BTB_BITS+2];

    assign ifBhtIdx = bus.ifPc[BHT_BITS+1:2];
    assign ifBtbIdx = bus.ifPc[BTB_BITS+1:2];
    assign ifTag    = bus.ifPc[31:BTB_BITS+2];
    assign btbHit   = btbValid[ifBtbIdx] && (btbTag[ifBtbIdx] == ifTag);
    assign ifPc4    = bus.ifPc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (exUpdate) begin
            if (taken && (bht[exBhtIdx] != 2'b11)) begin
                bht[exBhtIdx] <= bht[exBhtIdx] + 2'd1;
            end else if (!taken && (bht[exBhtIdx] != 2'b00)) begin
                bht[exBhtIdx] <= bht[exBhtIdx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btbValid <= '0;
        end else if (exUpdate && taken) begin
            btbValid[exBtbIdx] <= 1'b1;
        end
    end

    // Tag and target storage is gated by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && exUpdate && taken) begin
            btbTag[exBtbIdx]    <= exTag;
            btbTarget[exBtbIdx] <= target;
        end
    end

`ifdef RAS_EN
    localparam int RAS_BITS = $clog2(RAS_DEPTH);

    logic                btbRet   [BTB_ENTRIES];
    logic [31:0]         rasStack [RAS_DEPTH];
    logic [RAS_BITS-1:0] rasPtr;
    logic [RAS_BITS-1:0] rasTopIdx;
    logic [RAS_BITS:0]   rasCount;
    logic                rasPush;
    logic                rasPop;
    logic                rasHit;
    logic                unusedBits;

    assign rasPush   = bus.exValid & bus.exLink;
    assign rasPop    = bus.exValid & bus.exReturn;
    assign rasTopIdx = rasPtr - RAS_BITS'(1);

    always_ff @(posedge clk) begin
        if (!rst && exUpdate && taken) begin
            btbRet[exBtbIdx] <= bus.exReturn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rasPtr   <= '0;
            rasCount <= '0;
        end else if (rasPush && !rasPop) begin
            rasPtr <= rasPtr + RAS_BITS'(1);
            if (rasCount != (RAS_BITS+1)'(RAS_DEPTH)) begin
                rasCount <= rasCount + (RAS_BITS+1)'(1);
            end
        end else if (rasPop && !rasPush && (rasCount != '0)) begin
            rasPtr   <= rasTopIdx;
            rasCount <= rasCount - (RAS_BITS+1)'(1);
        end
    end

    // A push writes the free slot; push and pop together overwrite the current top in place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rasPush && rasPop) begin
                rasStack[rasTopIdx] <= bus.exPc4;
            end else if (rasPush) begin
                rasStack[rasPtr] <= bus.exPc4;
            end
        end
    end

    assign rasHit         = btbHit && btbRet[ifBtbIdx] && (rasCount != '0);
    assign bus.predTaken  = rasHit | (btbHit & bht[ifBhtIdx][1]);
    assign bus.predTarget = rasHit ? rasStack[rasTopIdx]
                          : (bus.predTaken ? btbTarget[ifBtbIdx] : ifPc4);
    assign unusedBits     = &{1'b0, bus.exInstr[31:26], bus.exPc[1:0], bus.exPredTaken};
`else
    logic unusedBits;

    assign bus.predTaken  = btbHit & bht[ifBhtIdx][1];
    assign bus.predTarget = bus.predTaken ? btbTarget[ifBtbIdx] : ifPc4;
    assign unusedBits     = &{1'b0, bus.exInstr[31:26], bus.exPc[1:0], bus.exPredTaken,
                              bus.exLink, bus.exReturn};
`endif
endmodule
